// File: rtl/led_pwm_bank_if.sv
// Config write port of the LED PWM bank: a write strobe held by the master
// until the bank raises cfg_ready.
interface led_pwm_bank_if #(
    parameter int CH_BITS  = 3,
    parameter int PWM_BITS = 8
);
    logic                cfg_we;
    logic [CH_BITS-1:0]  cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                cfg_ready;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty, input  cfg_ready);
    modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty, output cfg_ready);
endinterface

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM bank: one shared period counter, per-channel shadow
// settings committed at period boundaries, OFF/ON/PWM/BREATHE modes.
module led_pwm_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_i,
    input  logic [1:0]          mode_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic                commit_i,
    input  logic                step_i,
    input  logic [PWM_BITS-1:0] ctr_i,
    output logic                led_o
);
    typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_PWM = 2'd2, M_BRTH = 2'd3} mode_e;

    localparam logic [PWM_BITS-1:0] LMAX = '1;

    mode_e               sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [PWM_BITS-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
    logic [PWM_BITS-1:0] lvl_q, lvl_d;
    logic                up_q, up_d, led_q, led_d;

    always_comb begin
        sh_mode_d  = sh_mode_q;
        sh_duty_d  = sh_duty_q;
        act_mode_d = act_mode_q;
        act_duty_d = act_duty_q;
        lvl_d      = lvl_q;
        up_d       = up_q;
        if (wr_i) begin
            sh_mode_d = mode_e'(mode_i);
            sh_duty_d = duty_i;
        end
        if (commit_i) begin
            act_mode_d = sh_mode_q;
            act_duty_d = sh_duty_q;
            // Entering BREATHE seeds the level; staying in BREATHE only steps it.
            if (sh_mode_q == M_BRTH) begin
                if (act_mode_q != M_BRTH) begin
                    lvl_d = sh_duty_q;
                    up_d  = 1'b1;
                end else if (step_i) begin
                    if (up_q) begin
                        if (lvl_q == LMAX) begin
                            up_d  = 1'b0;
                            lvl_d = LMAX - 1'b1;
                        end else begin
                            lvl_d = lvl_q + 1'b1;
                        end
                    end else if (lvl_q == '0) begin
                        up_d  = 1'b1;
                        lvl_d = PWM_BITS'(1);
                    end else begin
                        lvl_d = lvl_q - 1'b1;
                    end
                end
            end
        end
        unique case (act_mode_q)
            M_OFF:   led_d = 1'b0;
            M_ON:    led_d = 1'b1;
            M_PWM:   led_d = (ctr_i < act_duty_q);
            default: led_d = (ctr_i < lvl_q);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_mode_q  <= M_OFF;
            sh_duty_q  <= '0;
            act_mode_q <= M_OFF;
            act_duty_q <= '0;
            lvl_q      <= '0;
            up_q       <= 1'b1;
            led_q      <= 1'b0;
        end else begin
            sh_mode_q  <= sh_mode_d;
            sh_duty_q  <= sh_duty_d;
            act_mode_q <= act_mode_d;
            act_duty_q <= act_duty_d;
            lvl_q      <= lvl_d;
            up_q       <= up_d;
            led_q      <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

module led_pwm_bank #(
    parameter int CHANNELS     = 8,
    parameter int PWM_BITS     = 8,
    parameter int RAMP_DIV_LEN = 4,
    parameter int CH_BITS      = 3
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_bank_if.slave       cfg,
    output logic                period_start,
    output logic [CHANNELS-1:0] led
);
    localparam logic [PWM_BITS-1:0] CMAX = '1;

    logic [PWM_BITS-1:0]     ctr_q, ctr_d;
    logic [RAMP_DIV_LEN-1:0] per_q, per_d;
    logic                    ps_q, ps_d;
    logic                    commit, step, accept;

    // Last cycle of the period: writes are held off so the commit sees stable shadows.
    assign commit        = (ctr_q == CMAX);
    assign step          = commit && (per_q == '1);
    assign accept        = cfg.cfg_we && !commit;
    assign cfg.cfg_ready = !commit;

    always_comb begin
        ctr_d = ctr_q + 1'b1;
        per_d = commit ? per_q + 1'b1 : per_q;
        ps_d  = commit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= '0;
            per_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            per_q <= per_d;
            ps_q  <= ps_d;
        end
    end

    assign period_start = ps_q;

    // Out-of-range channel indices match no lane and are silently absorbed.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_i     (accept && (cfg.cfg_ch == CH_BITS'(g))),
            .mode_i   (cfg.cfg_mode),
            .duty_i   (cfg.cfg_duty),
            .commit_i (commit),
            .step_i   (step),
            .ctr_i    (ctr_q),
            .led_o    (led[g])
        );
    end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Randomized + directed bench for led_pwm_bank against a per-period behavioural model.
module tb_led_pwm_bank;
    localparam int CH   = 4;
    localparam int PB   = 4;
    localparam int RD   = 1;
    localparam int CB   = 3;
    localparam int PER  = 1 << PB;
    localparam int MAXV = PER - 1;
    localparam int RN   = 1 << RD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps;
    logic [CH-1:0] led;

    led_pwm_bank_if #(.CH_BITS(CB), .PWM_BITS(PB)) bif ();

    led_pwm_bank #(.CHANNELS(CH), .PWM_BITS(PB), .RAMP_DIV_LEN(RD), .CH_BITS(CB)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (bif.slave),
        .period_start (ps),
        .led          (led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: edges since reset, completed periods, shadow/active settings, breathe state.
    int            m_n, m_per;
    int            sh_mode[CH], sh_duty[CH], a_mode[CH], a_duty[CH], lvl[CH];
    bit            up[CH];
    logic [CH-1:0] m_led, obs_led;
    bit            m_ps;

    task automatic chk(string tag, int unsigned got, int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_per = 0; m_led = '0; m_ps = 1'b0;
        for (int i = 0; i < CH; i++) begin
            sh_mode[i] = 0; sh_duty[i] = 0; a_mode[i] = 0; a_duty[i] = 0;
            lvl[i] = 0; up[i] = 1'b1;
        end
    endtask

    // One clock edge of the bank, expressed in terms of period position c.
    task automatic model_edge();
        int c;
        bit last, stp;
        c    = m_n % PER;
        last = (c == PER - 1);
        if (bif.cfg_we && !last && int'(bif.cfg_ch) < CH) begin
            sh_mode[bif.cfg_ch] = int'(bif.cfg_mode);
            sh_duty[bif.cfg_ch] = int'(bif.cfg_duty);
        end
        for (int i = 0; i < CH; i++)
            case (a_mode[i])
                0: m_led[i] = 1'b0;
                1: m_led[i] = 1'b1;
                2: m_led[i] = (c < a_duty[i]);
                default: m_led[i] = (c < lvl[i]);
            endcase
        m_ps = last;
        if (last) begin
            m_per++;
            stp = (m_per % RN) == 0;
            for (int i = 0; i < CH; i++) begin
                if (sh_mode[i] == 3) begin
                    if (a_mode[i] != 3) begin
                        lvl[i] = sh_duty[i]; up[i] = 1'b1;
                    end else if (stp) begin
                        if (up[i]) begin
                            if (lvl[i] == MAXV) begin up[i] = 1'b0; lvl[i] = MAXV - 1; end
                            else lvl[i] = lvl[i] + 1;
                        end else begin
                            if (lvl[i] == 0) begin up[i] = 1'b1; lvl[i] = 1; end
                            else lvl[i] = lvl[i] - 1;
                        end
                    end
                end
                a_mode[i] = sh_mode[i];
                a_duty[i] = sh_duty[i];
            end
        end
        m_n++;
    endtask

    // Called just after a posedge: check this cycle's outputs, then advance one edge.
    task automatic step();
        @(negedge clk);
        obs_led = led;
        chk("led", led, m_led);
        chk("period_start", ps, m_ps);
        chk("cfg_ready", bif.cfg_ready, (m_n % PER) != PER - 1);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(int c, int mode, int duty);
        bit acc;
        bif.cfg_we = 1'b1; bif.cfg_ch = CB'(c); bif.cfg_mode = 2'(mode); bif.cfg_duty = PB'(duty);
        for (int k = 0; k < 2; k++) begin
            acc = (m_n % PER) != PER - 1;
            step();
            if (acc) break;
        end
        bif.cfg_we = 1'b0;
    endtask

    task automatic align0();
        for (int k = 0; k < PER && (m_n % PER) != 0; k++) step();
    endtask

    task automatic count_ch(int c, output int n);
        n = 0;
        for (int k = 0; k < PER; k++) begin
            step();
            n += int'(obs_led[c]);
        end
    endtask

    task automatic async_reset(string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_led"}, led, 0);
        chk({tag, "_ready"}, bif.cfg_ready, 1);
        chk({tag, "_ps"}, ps, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt;
        bif.cfg_we = 1'b0; bif.cfg_ch = '0; bif.cfg_mode = '0; bif.cfg_duty = '0;
        model_reset();
        #2;
        chk("reset_led", led, 0);
        chk("reset_ready", bif.cfg_ready, 1);
        chk("reset_ps", ps, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All ON, then reset mid-period.
        for (int i = 0; i < CH; i++) wr(i, 1, 0);
        run(PER + 5);
        chk("all_on", led, 4'hF);
        async_reset("midrst");
        run(20);

        // PWM duty counts, including the 0 and full-scale edges.
        wr(1, 2, 5);  align0(); count_ch(1, cnt); chk("duty5_cnt", cnt, 5);
        wr(1, 2, 0);  align0(); count_ch(1, cnt); chk("duty0_cnt", cnt, 0);
        wr(1, 2, 15); align0(); count_ch(1, cnt); chk("duty15_cnt", cnt, 15);

        // Commit hold-off: write raised on the commit cycle is deferred one cycle.
        while ((m_n % PER) != PER - 1) step();
        chk("holdoff_ready", bif.cfg_ready, 0);
        wr(3, 2, 7);
        chk("holdoff_accept_pos", m_n % PER, 1);
        align0(); count_ch(3, cnt); chk("holdoff_cnt", cnt, 7);

        // Glitch-free update mid-period.
        wr(0, 2, 12); align0();
        cnt = 0;
        for (int k = 0; k < PER; k++) begin
            if (k == 5) begin
                bif.cfg_we = 1'b1; bif.cfg_ch = 3'd0; bif.cfg_mode = 2'd2; bif.cfg_duty = 4'd3;
            end else begin
                bif.cfg_we = 1'b0;
            end
            step();
            cnt += int'(obs_led[0]);
        end
        bif.cfg_we = 1'b0;
        chk("glitch_old_cnt", cnt, 12);
        count_ch(0, cnt); chk("glitch_new_cnt", cnt, 3);

        // Breathe through both bounces.
        wr(2, 3, 14);
        run(PER * 40);
        wr(2, 3, 9);
        run(PER * 6);

        // Invalid channel indices.
        wr(5, 1, 0);
        wr(7, 2, 9);
        run(PER * 3);

        // Random traffic with one mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                bif.cfg_we = 1'b0;
                async_reset("rnd_rst");
            end
            bif.cfg_we   = ($urandom % 6) == 0;
            bif.cfg_ch   = CB'($urandom % 8);
            bif.cfg_mode = 2'($urandom % 4);
            bif.cfg_duty = PB'($urandom % PER);
            step();
        end
        bif.cfg_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_pwm_bank.md
Name: led_pwm_bank

Overview:
Parametrised multi-channel LED PWM controller. It replaces per-LED fixed-function wave instances with a single bank that shares one counter. Each channel has its own mode (off / on / fixed duty / breathe) and duty or phase. Settings are written through a simple config port and committed glitch-free at PWM period boundaries. It sits between top-level control logic and the board LED pins.

Parameters:
CHANNELS, 8, number of LED outputs (1..16)
PWM_BITS, 8, PWM counter and duty width; period = 2^PWM_BITS clk cycles
RAMP_DIV_LEN, 4, breathe step occurs once every 2^RAMP_DIV_LEN PWM periods
CH_BITS, 3, width of cfg_ch; must be >= ceil(log2(CHANNELS)), minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_ch  in  CH_BITS  target channel index
cfg_mode  in  2  0=OFF, 1=ON, 2=PWM, 3=BREATHE
cfg_duty  in  PWM_BITS  duty (PWM mode) or start level (BREATHE mode)
cfg_ready  out  1  high when a write is accepted this cycle
period_start  out  1  one-cycle pulse at the first cycle of each PWM period
led  out  CHANNELS  LED drive, bit i = channel i

Behaviour:
- Reset behaviour (asynchronous, rst=1):
  - ctr=0, period counter=0.
  - All shadow and active modes = OFF; duties = 0; breathe levels = 0; directions = up.
  - Outputs: led=0, period_start=0, cfg_ready=1.
- ctr: PWM_BITS-bit free-running counter. Increments every clk; wraps from 2^PWM_BITS-1 to 0.
- Commit cycle: the cycle in which ctr == 2^PWM_BITS-1.
- cfg_ready = (ctr != 2^PWM_BITS-1). It is low only on the commit cycle.
- Write acceptance:
  - A write is accepted when cfg_we && cfg_ready.
  - An accepted write loads shadow_mode[cfg_ch] and shadow_duty[cfg_ch].
  - A write with cfg_ch >= CHANNELS is accepted but has no effect.
  - cfg_we on the commit cycle is dropped; the master must hold cfg_we until it sees cfg_ready.
  - Repeated writes to one channel within a period: the last one wins.
- Commit: on the commit cycle, every channel copies shadow to active. The new setting first affects led in the cycle where ctr==0.
- Breathe entry: if a channel's active mode becomes BREATHE from any other mode, level := shadow_duty and dir := up. Writing BREATHE over BREATHE does not reset the level.
- Period counter: RAMP_DIV_LEN bits, increments on each commit cycle. A breathe step fires on the commit cycle where it wraps to 0.
- Breathe step, applied to channels already in BREATHE:
  - dir up: level+1. If level == max, set dir = down and level = max-1.
  - dir down: level-1. If level == 0, set dir = up and level = 1.
  - Levels never wrap.
- LED compare (registered):
  - led[i] is registered from ctr and the active state, giving 1 cycle of latency.
  - OFF -> 0. ON -> 1.
  - PWM -> (ctr < duty_act).
  - BREATHE -> (ctr < level).
- Duty edges: duty 0 gives a constant 0. duty = 2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of 2^PWM_BITS cycles. Use ON mode for a full-on output.
- led alignment: led changes only at clk edges. Duty/level changes take effect only at period boundaries, so no runt pulses.
- period_start: registered; high in the cycle where ctr==0 is presented. It does not pulse in the first period after reset (ctr starts at 0 without a wrap).
- Reset mid-operation: asynchronous clear of all state and outputs; the counter restarts from 0.

Test Plan:
Bench config for all scenarios: PWM_BITS=4, CHANNELS=4, RAMP_DIV_LEN=1.
- Reset: assert rst mid-period with all channels ON -> led=0 and cfg_ready=1 immediately. After release, led stays 0 until writes are made.
- PWM duty: write ch1 PWM duty=5 -> from the next period, led[1] is high for exactly 5 of every 16 cycles, one cycle after ctr=0..4. Duty 0 -> always 0; duty 15 -> 15 of 16.
- Commit hold-off: raise cfg_we on a ctr==15 cycle -> cfg_ready=0 and no update. Holding cfg_we to the next cycle is accepted; the change is visible one period later.
- Glitch-free update: change ch0 duty 12->3 mid-period -> the current period still shows 12 high cycles; the next shows 3.
- Breathe: ch2 BREATHE start=14 -> levels per 2 periods are 14, 15, 14, 13, ... down to 0, then 1. No level outside 0..15.
- Invalid channel: write cfg_ch=5 -> led unchanged on all channels; cfg_ready behaviour is unaffected.
